// File: rtl/adder_axil_pkg.sv
// Shared definitions for the adder AXI4-Lite master.
// Contents: adder register offsets, the AXI OKAY response code and the FSM state type.
package adder_axil_pkg;

    localparam int unsigned OFF_OPA = 32'h0;
    localparam int unsigned OFF_OPB = 32'h4;
    localparam int unsigned OFF_RES = 32'h8;
    localparam int unsigned OFF_OVF = 32'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WB_A,
        S_WR_B,
        S_WB_B,
        S_RD_RES,
        S_RR_RES,
        S_RD_OVF,
        S_RR_OVF,
        S_DONE
    } state_e;

endpackage

// File: rtl/adder_axil_master_if.sv
// AXI4-Lite bundle between the adder master and the adder slave port.
// Parameters: DATA_WIDTH (data/strobe width), ADDR_WIDTH (address width).
// Modports: master drives AW/W/AR channels and B/R readies; slave is the mirror.
interface adder_axil_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/adder_axil_master.sv
// AXI4-Lite master for the memory-mapped adder: writes operand A and B, reads
// back sum and overflow, then presents them with a one-cycle done pulse.
// Ports: m1_axi_aclk/m1_axi_aresetn (clock, async active-low reset);
//        start/op_a/op_b (request), busy/done/result/overflow/err (result side);
//        m1_axi (AXI4-Lite master modport).
// Optional: define ADDER_MASTER_TIMEOUT_EN for a per-state watchdog of
//           TIMEOUT_CYCLES that forces err and a done pulse.
module adder_axil_master
    import adder_axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  m1_axi_aclk,
    input  logic                  m1_axi_aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  err,
    adder_axil_master_if.master   m1_axi
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_OPA = ADDR_WIDTH'(BASE_ADDR + OFF_OPA);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OPB = ADDR_WIDTH'(BASE_ADDR + OFF_OPB);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RES = ADDR_WIDTH'(BASE_ADDR + OFF_RES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OVF = ADDR_WIDTH'(BASE_ADDR + OFF_OVF);

    // Reject configurations the datapath cannot honour.
    if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("adder_axil_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES nonzero");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic [DATA_WIDTH-1:0] res_buf_q, res_buf_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

`ifdef ADDER_MASTER_TIMEOUT_EN
    logic [31:0]           cnt_q, cnt_d;
`endif

    logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    assign aw_hs_c = awvalid_q & m1_axi.awready;
    assign w_hs_c  = wvalid_q  & m1_axi.wready;
    assign b_hs_c  = bready_q  & m1_axi.bvalid;
    assign ar_hs_c = arvalid_q & m1_axi.arready;
    assign r_hs_c  = rready_q  & m1_axi.rvalid;

    // Next-state and registered-output logic; valids are raised on entry to a state.
    always_comb begin
        state_d   = state_q;
        opb_d     = opb_q;
        res_buf_d = res_buf_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    opb_d     = op_b;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awaddr_d  = ADDR_OPA;
                    wdata_d   = op_a;
                    state_d   = S_WR_A;
                end
            end
            S_WR_A, S_WR_B: begin
                if (aw_hs_c) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs_c) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs_c) && (w_done_q | w_hs_c)) begin
                    bready_d = 1'b1;
                    state_d  = (state_q == S_WR_A) ? S_WB_A : S_WB_B;
                end
            end
            S_WB_A: begin
                if (b_hs_c) begin
                    bready_d  = 1'b0;
                    err_d     = err_q | (m1_axi.bresp != RESP_OKAY);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awaddr_d  = ADDR_OPB;
                    wdata_d   = opb_q;
                    state_d   = S_WR_B;
                end
            end
            S_WB_B: begin
                if (b_hs_c) begin
                    bready_d  = 1'b0;
                    err_d     = err_q | (m1_axi.bresp != RESP_OKAY);
                    arvalid_d = 1'b1;
                    araddr_d  = ADDR_RES;
                    state_d   = S_RD_RES;
                end
            end
            S_RD_RES, S_RD_OVF: begin
                if (ar_hs_c) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = (state_q == S_RD_RES) ? S_RR_RES : S_RR_OVF;
                end
            end
            S_RR_RES: begin
                if (r_hs_c) begin
                    rready_d  = 1'b0;
                    res_buf_d = m1_axi.rdata;
                    err_d     = err_q | (m1_axi.rresp != RESP_OKAY);
                    arvalid_d = 1'b1;
                    araddr_d  = ADDR_OVF;
                    state_d   = S_RD_OVF;
                end
            end
            S_RR_OVF: begin
                if (r_hs_c) begin
                    rready_d = 1'b0;
                    ovf_d    = m1_axi.rdata[0];
                    result_d = res_buf_q;
                    err_d    = err_q | (m1_axi.rresp != RESP_OKAY);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ADDER_MASTER_TIMEOUT_EN
        // Watchdog: abandon the transfer with err set; published results are kept.
        if (state_q != S_IDLE && state_q != S_DONE && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            result_d  = result_q;
            ovf_d     = ovf_q;
            err_d     = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_DONE;
        end
        cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
`endif
    end

    // State and output registers.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state_q   <= S_IDLE;
            opb_q     <= '0;
            res_buf_q <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            opb_q     <= opb_d;
            res_buf_q <= res_buf_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef ADDER_MASTER_TIMEOUT_EN
    // Per-state cycle counter, restarted on every state change.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;
    assign err      = err_q;

    assign m1_axi.awaddr  = awaddr_q;
    assign m1_axi.awvalid = awvalid_q;
    assign m1_axi.wdata   = wdata_q;
    assign m1_axi.wstrb   = '1;
    assign m1_axi.wvalid  = wvalid_q;
    assign m1_axi.bready  = bready_q;
    assign m1_axi.araddr  = araddr_q;
    assign m1_axi.arvalid = arvalid_q;
    assign m1_axi.rready  = rready_q;

endmodule

// File: tb/tb_adder_axil_master.sv
// Directed bench for adder_axil_master with a small behavioural adder slave.
module tb_adder_axil_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done, overflow, err;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    // Slave knobs
    int          aw_delay = 0;
    logic [1:0]  bresp_b  = 2'b00;
    logic        ar_block = 1'b0;

    adder_axil_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) axi ();

    adder_axil_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .overflow(overflow), .err(err),
        .m1_axi(axi)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural adder slave ----------------
    logic [31:0] sreg_a, sreg_b, s_wdata;
    logic [7:0]  s_awaddr;
    logic        s_aw_got, s_w_got;
    int          aw_wait;
    logic        aw_fire, w_fire;
    logic [7:0]  wr_addr_c;
    logic [31:0] wr_data_c;
    logic [32:0] sum_c;
    int          wr_n = 0, rd_n = 0, b_cnt = 0, aw_cyc = 0, w_cyc = 0;
    logic [7:0]  wr_log_addr [64];
    logic [31:0] wr_log_data [64];
    logic [7:0]  rd_log_addr [64];

    assign axi.awready = axi.awvalid && (aw_wait >= aw_delay);
    assign axi.wready  = 1'b1;
    assign axi.arready = !ar_block;
    assign aw_fire   = axi.awvalid && axi.awready;
    assign w_fire    = axi.wvalid && axi.wready;
    assign wr_addr_c = aw_fire ? axi.awaddr : s_awaddr;
    assign wr_data_c = w_fire ? axi.wdata : s_wdata;
    assign sum_c     = {1'b0, sreg_a} + {1'b0, sreg_b};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= '0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_awaddr <= '0; s_wdata <= '0;
            sreg_a <= '0; sreg_b <= '0; aw_wait <= 0;
        end else begin
            if (aw_fire) aw_wait <= 0;
            else if (axi.awvalid) aw_wait <= aw_wait + 1;
            if (aw_fire) begin s_aw_got <= 1'b1; s_awaddr <= axi.awaddr; end
            if (w_fire)  begin s_w_got  <= 1'b1; s_wdata  <= axi.wdata;  end
            if ((s_aw_got || aw_fire) && (s_w_got || w_fire)) begin
                if (wr_addr_c == 8'h00) sreg_a <= wr_data_c;
                if (wr_addr_c == 8'h04) sreg_b <= wr_data_c;
                axi.bvalid <= 1'b1;
                axi.bresp  <= (wr_addr_c == 8'h04) ? bresp_b : 2'b00;
                s_aw_got <= 1'b0; s_w_got <= 1'b0;
                wr_log_addr[wr_n % 64] <= wr_addr_c;
                wr_log_data[wr_n % 64] <= wr_data_c;
                wr_n <= wr_n + 1;
            end else if (axi.bvalid && axi.bready) begin
                axi.bvalid <= 1'b0;
            end
            if (axi.bvalid && axi.bready) b_cnt <= b_cnt + 1;
            if (axi.arvalid && axi.arready) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= (axi.araddr == 8'h08) ? sum_c[31:0] :
                              (axi.araddr == 8'h0C) ? {31'd0, sum_c[32]} : 32'd0;
                rd_log_addr[rd_n % 64] <= axi.araddr;
                rd_n <= rd_n + 1;
            end else if (axi.rvalid && axi.rready) begin
                axi.rvalid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (axi.awvalid) aw_cyc <= aw_cyc + 1;
        if (axi.wvalid)  w_cyc  <= w_cyc + 1;
    end

    // Pulse start then wait (bounded) for done; returns at the negedge where done=1.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int cyc, output bit ok);
        @(negedge clk); start = 1'b1; op_a = a; op_b = b; cyc = 1;
        @(negedge clk); start = 1'b0; cyc = 2;
        ok = 1'b0;
        while (cyc < 300) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, overflow} !== 4'b0000 || result !== 32'd0) begin
            failures++; $display("FAIL reset_outputs: busy/done/err/ovf=%b result=%h, want 0000/0", {busy, done, err, overflow}, result);
        end
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0 ||
            axi.awaddr !== 8'h0 || axi.araddr !== 8'h0 || axi.wdata !== 32'h0) begin
            failures++; $display("FAIL reset_axi: v/r=%b aw=%h ar=%h wd=%h, want all 0",
                {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, axi.awaddr, axi.araddr, axi.wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc; bit ok; int wb; int rb;
        wb = wr_n; rb = rd_n;
        do_op(32'd5, 32'd7, cyc, ok);
        checks++;
        if (!ok || cyc != 10) begin failures++; $display("FAIL basic_latency: got cycle %0d ok=%0d, want 10", cyc, ok); end
        checks++;
        if (result !== 32'd12 || overflow !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_result: res=%0d ovf=%b err=%b busy=%b, want 12/0/0/0", result, overflow, err, busy);
        end
        checks++;
        if (wr_log_addr[wb % 64] !== 8'h00 || wr_log_data[wb % 64] !== 32'd5 ||
            wr_log_addr[(wb + 1) % 64] !== 8'h04 || wr_log_data[(wb + 1) % 64] !== 32'd7) begin
            failures++; $display("FAIL basic_writes: %h=%0d %h=%0d, want 00=5 04=7", wr_log_addr[wb % 64],
                wr_log_data[wb % 64], wr_log_addr[(wb + 1) % 64], wr_log_data[(wb + 1) % 64]);
        end
        checks++;
        if (rd_n - rb != 2 || rd_log_addr[rb % 64] !== 8'h08 || rd_log_addr[(rb + 1) % 64] !== 8'h0C) begin
            failures++; $display("FAIL basic_reads: n=%0d %h %h, want 2 08 0C", rd_n - rb, rd_log_addr[rb % 64], rd_log_addr[(rb + 1) % 64]);
        end
        checks++;
        if (axi.wstrb !== 4'hF) begin failures++; $display("FAIL wstrb: got %h want F", axi.wstrb); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_pulse: done=%b one cycle later, want 0", done); end
    endtask

    task automatic test_overflow();
        int cyc; bit ok;
        do_op(32'hFFFF_FFFF, 32'd1, cyc, ok);
        checks++;
        if (!ok || result !== 32'd0 || overflow !== 1'b1 || err !== 1'b0) begin
            failures++; $display("FAIL overflow: ok=%0d res=%h ovf=%b err=%b, want 1/0/1/0", ok, result, overflow, err);
        end
    endtask

    task automatic test_aw_late();
        int cyc; bit ok; int a0, w0, b0;
        aw_delay = 3;
        a0 = aw_cyc; w0 = w_cyc; b0 = b_cnt;
        do_op(32'd100, 32'd23, cyc, ok);
        aw_delay = 0;
        checks++;
        if (aw_cyc - a0 != 8 || w_cyc - w0 != 2) begin
            failures++; $display("FAIL aw_late_valids: aw cycles=%0d w cycles=%0d, want 8 and 2", aw_cyc - a0, w_cyc - w0);
        end
        checks++;
        if (b_cnt - b0 != 2) begin failures++; $display("FAIL aw_late_bresp: B handshakes=%0d, want 2", b_cnt - b0); end
        checks++;
        if (!ok || result !== 32'd123 || err !== 1'b0) begin
            failures++; $display("FAIL aw_late_result: ok=%0d res=%0d err=%b, want 1/123/0", ok, result, err);
        end
    endtask

    task automatic test_bresp_err();
        int cyc; bit ok;
        bresp_b = 2'b10;
        do_op(32'd20, 32'd22, cyc, ok);
        bresp_b = 2'b00;
        checks++;
        if (!ok || err !== 1'b1 || result !== 32'd42 || cyc != 10) begin
            failures++; $display("FAIL bresp_err: ok=%0d err=%b res=%0d cyc=%0d, want 1/1/42/10", ok, err, result, cyc);
        end
        do_op(32'd1, 32'd2, cyc, ok);
        checks++;
        if (!ok || err !== 1'b0 || result !== 32'd3) begin
            failures++; $display("FAIL bresp_clear: ok=%0d err=%b res=%0d, want 1/0/3", ok, err, result);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc; bit ok;
        @(negedge clk); start = 1'b1; op_a = 32'd9; op_b = 32'd10;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op_a = 32'd1000; op_b = 32'd1000;
        @(negedge clk); start = 1'b0;
        cyc = 4; ok = 1'b0;
        while (cyc < 300) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk); cyc++;
        end
        checks++;
        if (!ok || result !== 32'd19) begin failures++; $display("FAIL busy_start_result: ok=%0d res=%0d, want 1/19", ok, result); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || axi.awvalid !== 1'b0) begin
            failures++; $display("FAIL busy_start_queued: busy=%b awvalid=%b, want 0/0", busy, axi.awvalid);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok;
        do_op(32'h1234_5678, 32'h1111_1111, cyc, ok);
        checks++;
        if (!ok || result !== 32'h2345_6789 || overflow !== 1'b0) begin
            failures++; $display("FAIL b2b_first: ok=%0d res=%h ovf=%b, want 1/23456789/0", ok, result, overflow);
        end
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, cyc, ok);
        checks++;
        if (!ok || result !== 32'hFFFF_FFFE || overflow !== 1'b0 || cyc != 10) begin
            failures++; $display("FAIL b2b_second: ok=%0d res=%h ovf=%b cyc=%0d, want 1/FFFFFFFE/0/10", ok, result, overflow, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok; bit hit;
        @(negedge clk); start = 1'b1; op_a = 32'd50; op_b = 32'd60;
        @(negedge clk); start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (axi.rready && axi.araddr == 8'h08) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL reset_mid_reach: RR_RES not reached, got hit=%0d want 1", hit); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, overflow, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 9'b0 ||
            result !== 32'd0 || axi.araddr !== 8'h0 || axi.wdata !== 32'h0) begin
            failures++; $display("FAIL reset_mid_outputs: flags=%b res=%h ar=%h wd=%h, want all 0",
                {busy, done, err, overflow, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, result, axi.araddr, axi.wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        do_op(32'd3, 32'd4, cyc, ok);
        checks++;
        if (!ok || result !== 32'd7 || err !== 1'b0 || cyc != 10) begin
            failures++; $display("FAIL reset_mid_rerun: ok=%0d res=%0d err=%b cyc=%0d, want 1/7/0/10", ok, result, err, cyc);
        end
    endtask

`ifdef ADDER_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int n; bit ok;
        ar_block = 1'b1;
        @(negedge clk); start = 1'b1; op_a = 32'd8; op_b = 32'd8;
        @(negedge clk); start = 1'b0;
        n = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (axi.arvalid) n++;
            @(negedge clk);
        end
        ar_block = 1'b0;
        checks++;
        if (!ok || n != 16) begin failures++; $display("FAIL timeout_cycles: ok=%0d arvalid cycles=%0d, want 1/16", ok, n); end
        checks++;
        if (err !== 1'b1 || axi.arvalid !== 1'b0 || result !== 32'd7) begin
            failures++; $display("FAIL timeout_state: err=%b arvalid=%b res=%0d, want 1/0/7", err, axi.arvalid, result);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_aw_late();
        test_bresp_err();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef ADDER_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_axil_master.md
Name:
adder_axil_master

Overview:
AXI4-Lite master that drives the team's memory-mapped adder slave: on a start pulse it writes operand A and operand B, reads back the sum and overflow registers, then presents them on a simple result interface. It sits between local control logic and the adder's s1_axi_* slave port.

Parameters:
DATA_WIDTH, 32, data bus, operand and result width; must be a multiple of 8
ADDR_WIDTH, 8, AXI address width
BASE_ADDR, 0, adder base address; register offsets come from the package
TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature

Ports:
m1_axi_aclk  in  1  clock
m1_axi_aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle request; ignored while busy=1
op_a  in  DATA_WIDTH  operand A, sampled when start is accepted
op_b  in  DATA_WIDTH  operand B, sampled when start is accepted
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse when result, overflow and err are valid
result  out  DATA_WIDTH  sum read from offset 0x8
overflow  out  1  bit 0 of the read at offset 0xC
err  out  1  set if any BRESP or RRESP was not OKAY (or a timeout fired)
m1_axi_awaddr  out  ADDR_WIDTH  write address
m1_axi_awvalid  out  1  write address valid
m1_axi_awready  in  1  write address ready
m1_axi_wdata  out  DATA_WIDTH  write data
m1_axi_wstrb  out  DATA_WIDTH/8  write strobes, always all ones
m1_axi_wvalid  out  1  write data valid
m1_axi_wready  in  1  write data ready
m1_axi_bresp  in  2  write response
m1_axi_bvalid  in  1  write response valid
m1_axi_bready  out  1  write response ready
m1_axi_araddr  out  ADDR_WIDTH  read address
m1_axi_arvalid  out  1  read address valid
m1_axi_arready  in  1  read address ready
m1_axi_rdata  in  DATA_WIDTH  read data
m1_axi_rresp  in  2  read response
m1_axi_rvalid  in  1  read data valid
m1_axi_rready  out  1  read data ready

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. All valid/ready outputs, busy, done, err, overflow and result are 0; awaddr, araddr and wdata are 0.
- FSM sequence: IDLE -> WR_A -> WB_A -> WR_B -> WB_B -> RD_RES -> RR_RES -> RD_OVF -> RR_OVF -> DONE -> IDLE.
- IDLE: when start=1, latch op_a and op_b, clear err, set busy, go to WR_A on the next edge.
- WR_x:
  - Assert awvalid and wvalid together, with awaddr=BASE_ADDR+offset and wdata equal to the latched operand.
  - Each valid drops independently on the cycle after its own ready is seen; valids never drop before their handshake.
  - Leave WR_x once both handshakes are done (same cycle or different cycles).
- WB_x: bready=1; on bvalid, err|=(bresp!=2'b00) and advance.
- RD_x: arvalid=1 with araddr set, held until arready.
- RR_x: rready=1; on rvalid, capture rdata (result register, or bit 0 into overflow), err|=(rresp!=2'b00), advance.
- DONE: done=1 for exactly one cycle, busy drops the same cycle, then return to IDLE. result and overflow hold until the next done.
- Latency with a zero-wait slave: start to done is 10 cycles.
- Boundaries:
  - An error response does not abort the sequence; the remaining transfers complete.
  - start asserted while busy=1 is dropped, not queued.
  - No AXI valid depends combinationally on any AXI ready.
  - Reset mid-transfer deasserts all valids immediately.

Optional Feature:
- ADDER_MASTER_TIMEOUT_EN defined: a counter restarts on every state change. If it reaches TIMEOUT_CYCLES in any non-IDLE/DONE state, drop all valids and readies, set err=1, go to DONE (done still pulses once, result unchanged).
- Not defined: no counter and no timeout; the FSM waits indefinitely.

Decomposition:
- Package adder_axil_pkg: offsets OFF_OPA=0x0, OFF_OPB=0x4, OFF_RES=0x8, OFF_OVF=0xC; RESP_OKAY=2'b00; FSM state enum.
- No sub-module; the FSM and datapath stay in one module.

Test Plan:
- Zero-wait slave, op_a=5, op_b=7 -> writes 0x0=5 then 0x4=7, reads 0x8 then 0xC; done at cycle 10 with result=12, overflow=0, err=0.
- op_a=0xFFFFFFFF, op_b=1, slave returns 0 and 1 -> result=0, overflow=1.
- awready 3 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one B handshake.
- Slave returns bresp=2'b10 on the operand B write -> sequence completes, done pulses, err=1; the next clean start clears err.
- Reset asserted while in RR_RES -> all outputs return to reset values immediately; a later start runs the full sequence correctly.
- ADDER_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, arready tied 0 -> done and err at 16 cycles into RD_RES, arvalid deasserted.
